// File: rtl/gray_counter_n.sv
// gray_counter_n: parametrised up/down Gray-code counter with Gray-coded
// parallel load, sticky overflow and a one-cycle wrap pulse.
//
// Optional feature: define GRAY_COUNTER_SAT_EN to saturate at the count
// limits instead of wrapping modulo 2^WIDTH.
//
// Parameters:
//   WIDTH     counter width in bits (>= 2)
//   RESET_VAL binary value on reset and at power-up
// Ports:
//   Clk       rising-edge clock
//   Reset     synchronous active-high reset
//   En        count enable, one step per cycle
//   Up        1 = increment, 0 = decrement
//   Load      synchronous parallel load (beats En)
//   LoadGray  Gray-coded load value
//   ClrOvf    clears Overflow (a same-cycle wrap event wins)
//   Output    registered Gray-coded count
//   Binary    registered binary count
//   Overflow  registered sticky wrap/limit flag
//   Wrap      registered one-cycle pulse per wrap/limit event
module gray_counter_n #(
    parameter int unsigned          WIDTH     = 3,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadGray,
    input  logic             ClrOvf,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES   = '1;
    localparam logic [WIDTH-1:0] ZERO       = '0;
    localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

    // Declaration initialisers give the power-up state without a Reset pulse.
    logic [WIDTH-1:0] bin  = RESET_VAL;
    logic [WIDTH-1:0] gray = RESET_GRAY;
    logic             ovf  = 1'b0;
    logic             wrap = 1'b0;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin_nxt;
    logic             ovf_nxt;
    logic             wrap_evt;

    // Gray-to-binary of the load value: each bit is the XOR of all Gray bits above and at it.
    always_comb begin
        load_bin            = '0;
        load_bin[WIDTH-1]   = LoadGray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ LoadGray[i];
        end
    end

    // Next-state: load beats count; a wrap event sets Overflow even against ClrOvf.
    always_comb begin
        bin_nxt  = bin;
        ovf_nxt  = ClrOvf ? 1'b0 : ovf;
        wrap_evt = En && !Load && (Up ? (bin == ALL_ONES) : (bin == ZERO));
        if (Load) begin
            bin_nxt = load_bin;
        end else if (En) begin
            if (wrap_evt) begin
                ovf_nxt = 1'b1;
            end
`ifdef GRAY_COUNTER_SAT_EN
            if (!wrap_evt) begin
                bin_nxt = Up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
            end
`else
            bin_nxt = Up ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
`endif
        end
    end

    // State registers; Gray output is encoded from the next binary value so both update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bin  <= RESET_VAL;
            gray <= RESET_GRAY;
            ovf  <= 1'b0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= bin_nxt ^ (bin_nxt >> 1);
            ovf  <= ovf_nxt;
            wrap <= wrap_evt;
        end
    end

    assign Output   = gray;
    assign Binary   = bin;
    assign Overflow = ovf;
    assign Wrap     = wrap;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: self-checking bench for gray_counter_n. Two instances
// (WIDTH=3/RESET_VAL=0 and WIDTH=4/RESET_VAL=5) share stimulus and are
// compared every cycle against an integer reference model, plus directed
// literal checks. Honours GRAY_COUNTER_SAT_EN in the model.
module tb_gray_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       up  = 1'b0;
    logic       ld  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] lg  = '0;

    logic [2:0] out3, bin3;
    logic       ovf3, wrp3;
    logic [3:0] out4, bin4;
    logic       ovf4, wrp4;

    int n_asrt = 0;
    int n_fail = 0;

    // Reference model state
    int m_b3 = 0;
    int m_b4 = 5;
    bit m_o3 = 0, m_o4 = 0, m_w3 = 0, m_w4 = 0;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(3), .RESET_VAL(3'd0)) dut3 (
        .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(ld),
        .LoadGray(lg[2:0]), .ClrOvf(clr),
        .Output(out3), .Binary(bin3), .Overflow(ovf3), .Wrap(wrp3)
    );

    gray_counter_n #(.WIDTH(4), .RESET_VAL(4'd5)) dut4 (
        .Clk(clk), .Reset(rst), .En(en), .Up(up), .Load(ld),
        .LoadGray(lg), .ClrOvf(clr),
        .Output(out4), .Binary(bin4), .Overflow(ovf4), .Wrap(wrp4)
    );

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    // Inverse Gray by search over the whole code space.
    function automatic int from_gray(input int w, input int g);
        for (int v = 0; v < (1 << w); v++) begin
            if (to_gray(v) == g) return v;
        end
        return -1;
    endfunction

    task automatic model_step(input int w, input int rv, inout int b, inout bit o, inout bit wr,
                              input bit r, input bit l, input bit e, input bit u,
                              input bit c, input int g);
        int modulus;
        bit at_limit;
        modulus = 1 << w;
        if (r) begin
            b = rv; o = 0; wr = 0;
        end else if (l) begin
            b = from_gray(w, g % modulus);
            wr = 0;
            if (c) o = 0;
        end else if (e) begin
            at_limit = u ? (b == modulus - 1) : (b == 0);
            if (c) o = 0;
            if (at_limit) begin
                wr = 1; o = 1;
            end else begin
                wr = 0;
            end
`ifdef GRAY_COUNTER_SAT_EN
            if (!at_limit) b = u ? b + 1 : b - 1;
`else
            b = u ? (b + 1) % modulus : (b + modulus - 1) % modulus;
`endif
        end else begin
            wr = 0;
            if (c) o = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("w3_gray", 32'(out3), 32'(to_gray(m_b3)));
        chk("w3_bin",  32'(bin3), 32'(m_b3));
        chk("w3_ovf",  32'(ovf3), 32'(m_o3));
        chk("w3_wrap", 32'(wrp3), 32'(m_w3));
        chk("w4_gray", 32'(out4), 32'(to_gray(m_b4)));
        chk("w4_bin",  32'(bin4), 32'(m_b4));
        chk("w4_ovf",  32'(ovf4), 32'(m_o4));
        chk("w4_wrap", 32'(wrp4), 32'(m_w4));
    endtask

    // One clock: drive at negedge, advance model at posedge, sample 1 time unit later.
    task automatic cycle(input bit r, input bit l, input bit e, input bit u,
                         input bit c, input logic [3:0] g);
        @(negedge clk);
        rst = r; ld = l; en = e; up = u; clr = c; lg = g;
        @(posedge clk);
        model_step(3, 0, m_b3, m_o3, m_w3, r, l, e, u, c, int'(g[2:0]));
        model_step(4, 5, m_b4, m_o4, m_w4, r, l, e, u, c, int'(g));
        #1;
        check_all();
    endtask

    initial begin
        int up_seq [8] = '{1, 3, 2, 6, 7, 5, 4, 0};

        // Power-up values without any Reset pulse
        #1;
        check_all();
        chk("pwrup_gray4", 32'(out4), 32'h7);

        cycle(1, 0, 0, 0, 0, 4'h0);

        // Up-count through the wrap
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 1, 1, 0, 4'h0);
`ifndef GRAY_COUNTER_SAT_EN
            if (i < 8) chk("upseq_gray", 32'(out3), 32'(up_seq[i]));
            chk("upseq_wrap", 32'(wrp3), (i == 7) ? 32'd1 : 32'd0);
`endif
        end

        // Overflow clear with no wrap event
        cycle(0, 0, 0, 1, 1, 4'h0);
        chk("clr_ovf", 32'(ovf3), 32'd0);

        // Down-count from reset
        cycle(1, 0, 0, 0, 0, 4'h0);
        cycle(0, 0, 1, 0, 0, 4'h0);
        chk("down_wrap", 32'(wrp3), 32'd1);
        chk("down_ovf",  32'(ovf3), 32'd1);
`ifndef GRAY_COUNTER_SAT_EN
        chk("down_gray", 32'(out3), 32'b100);
        chk("down_bin",  32'(bin3), 32'd7);
`endif
        cycle(0, 0, 1, 0, 0, 4'h0);
        cycle(0, 0, 1, 0, 0, 4'h0);

        // Load beats En; then count up from the loaded value
        cycle(0, 1, 1, 1, 0, 4'b0110);
        chk("load_gray", 32'(out3), 32'b110);
        chk("load_bin",  32'(bin3), 32'd4);
        chk("load_wrap", 32'(wrp3), 32'd0);
        cycle(0, 0, 1, 1, 0, 4'h0);
        chk("postload_gray", 32'(out3), 32'b111);
        chk("postload_bin",  32'(bin3), 32'd5);

        // Load of the current value: no step, no wrap
        cycle(0, 1, 1, 1, 0, 4'b0111);

        // ClrOvf coinciding with a wrap event: the set wins
        cycle(0, 1, 0, 1, 1, 4'b0100);
        chk("load7_ovf_cleared", 32'(ovf3), 32'd0);
        cycle(0, 0, 1, 1, 1, 4'h0);
        chk("clr_vs_wrap_ovf", 32'(ovf3), 32'd1);

        // Width-4 reset mid-count overriding Load and En
        cycle(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 4'h0);
        chk("w4_count9", 32'(bin4), 32'd9);
        cycle(1, 1, 1, 1, 1, 4'b1111);
        chk("w4_rst_bin",  32'(bin4), 32'd5);
        chk("w4_rst_gray", 32'(out4), 32'b0111);
        cycle(0, 0, 0, 1, 0, 4'h0);
        cycle(0, 0, 0, 0, 0, 4'h0);
        chk("w4_hold_bin", 32'(bin4), 32'd5);

        // Up/down toggle around the limit gives back-to-back events
        cycle(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, i[0], 0, 4'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
                  ($urandom_range(0, 99) < 80), 1'($urandom), ($urandom_range(0, 99) < 8),
                  4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter: the successor to the fixed 3-bit Gray counter, with configurable width, up/down counting, a synchronous Gray-coded parallel load and a clearable sticky overflow. It drives Gray-coded and binary count values to downstream logic such as clock-domain-crossing pointers, sequence generators and test counters. Optionally, it saturates at its limits instead of wrapping. All outputs are registered.

## Interface
- WIDTH, 3, counter width in bits; must be at least 2.
- RESET_VAL, 0, binary value loaded on reset and at power-up; width WIDTH.

- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  count enable; one step per cycle while high.
- Up  in  1  direction: 1 = increment, 0 = decrement.
- Load  in  1  synchronous parallel load.
- LoadGray  in  WIDTH  Gray-coded load value.
- ClrOvf  in  1  clears Overflow.
- Output  out  WIDTH  current count, Gray-coded.
- Binary  out  WIDTH  current count, binary.
- Overflow  out  1  sticky wrap/limit flag.
- Wrap  out  1  one-cycle pulse on a wrap or limit event.

## Operation
- State:
  - Binary count register `bin[WIDTH-1:0]`.
  - Registered `Output = bin ^ (bin >> 1)`, updated in the same edge as `bin`; no combinational path from any input to any output.
  - `Overflow` and `Wrap` registers.
- Per-edge priority:
  1. Reset: `bin` = RESET_VAL, Overflow = 0, Wrap = 0.
  2. Load: `bin` = Gray-to-binary(LoadGray), where `b[MSB] = g[MSB]` and `b[i] = b[i+1] ^ g[i]`.
     - Wrap = 0.
     - Overflow is unaffected except for ClrOvf.
     - En is ignored.
  3. En: `bin` = `bin` ± 1 (modulo 2^WIDTH) per Up.
  4. Otherwise hold; Wrap = 0.
- Wrap event: En=1, Load=0, and either Up=1 with `bin` = all-ones, or Up=0 with `bin` = 0.
  - On a wrap event: Wrap = 1 for the next cycle, and Overflow is set.
- Overflow:
  - Sticky until ClrOvf or Reset.
  - ClrOvf with no wrap event in the same cycle: Overflow = 0.
  - Wrap event and ClrOvf in the same cycle: the set wins, so Overflow = 1.
- Changing Up between cycles is legal. Each step moves the Gray output by exactly one bit.
- Power-up: registers initialise to their reset values without a Reset pulse.

## Timing
- Latency: one cycle. An input sampled at edge N is visible on the outputs after edge N.
- Reset values: Output = Gray(RESET_VAL), Binary = RESET_VAL, Overflow = 0, Wrap = 0.
- Wrap is high for exactly one cycle per event. It is high on consecutive cycles if consecutive events occur (e.g. WIDTH wrap oscillation via the Up toggle).
- Reset asserted mid-count overrides Load, En and ClrOvf in that cycle. Counting resumes from RESET_VAL on the first edge with Reset low.
- Load of the current value still counts as a load: no step occurs and Wrap = 0.

## Configuration
- `GRAY_COUNTER_SAT_EN` defined (saturating mode):
  - A wrap event leaves `bin` unchanged: holds at all-ones when counting up, at 0 when counting down.
  - Wrap still pulses and Overflow still sets on each blocked step.
  - Steps away from the limit proceed normally.
- `GRAY_COUNTER_SAT_EN` undefined (wrapping mode, default): modulo wrap as described in Operation.

## Test plan
- WIDTH=3, reset, then En=1, Up=1 for 9 cycles:
  - Output = 000, 001, 011, 010, 110, 111, 101, 100, 000.
  - Wrap high only in the cycle after the 100→000 step.
  - Overflow = 1 from that cycle on.
- Down-count from reset with WIDTH=3, En=1, Up=0:
  - First step gives Output = 100 and Binary = 7, with Wrap = 1 and Overflow = 1.
  - Next steps give Output = 101, then 111.
- Load with WIDTH=3, Load=1, LoadGray=110, En=1:
  - Output = 110, Binary = 4, Wrap = 0.
  - Then En only, Up=1: Output = 111, Binary = 5.
- ClrOvf:
  - With Overflow = 1, pulse ClrOvf for one cycle: Overflow = 0.
  - Assert ClrOvf in the same cycle as the 100→000 wrap: Overflow stays 1.
- Reset mid-count with WIDTH=4, RESET_VAL=5:
  - Count to Binary = 9, then assert Reset together with Load and En: Binary = 5, Output = 0111, Overflow = 0.
  - Hold with En=0: the value remains stable.
- With `GRAY_COUNTER_SAT_EN`, WIDTH=3:
  - Count up past 7: Output stays 100, and Wrap pulses every cycle while En=1 and Up=1.
  - Set Up=0: Output = 101.
